// File: rtl/yzh_komut_birimi.sv
// yzh_komut_birimi: issue-side controller for the convolution accelerator.
// Decodes custom load/clear/run instructions, drives the accelerator's
// load/clear/run strobes, tracks the filter/data fill levels, stalls the
// pipeline while an instruction is in flight and returns the run result to
// the register-file writeback path.
module yzh_komut_birimi #(
  parameter int unsigned MATRIS_BOYUT = 16,
  parameter int unsigned ZAMAN_ASIMI  = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        komut_gecerli_i,
  input  logic [31:0] buyruk_i,
  input  logic [31:0] rs1_veri_i,
  input  logic [31:0] rs2_veri_i,
  output logic        komut_hazir_o,
  output logic        stall_o,
  output logic        blok_aktif_o,
  output logic        filtre_rs1_en_o,
  output logic        filtre_rs2_en_o,
  output logic        filtre_sil_o,
  output logic        veri_rs1_en_o,
  output logic        veri_rs2_en_o,
  output logic        veri_sil_o,
  output logic        conv_yap_en_o,
  output logic [31:0] yzh_rs1_o,
  output logic [31:0] yzh_rs2_o,
  input  logic [31:0] yzh_sonuc_i,
  input  logic        yzh_hazir_i,
  output logic        yaz_gecerli_o,
  output logic [4:0]  yaz_adres_o,
  output logic [31:0] yaz_veri_o,
  output logic        hata_o
);

  localparam logic [6:0]      OPKOD   = 7'b0001011;
  localparam int unsigned     SAY_W   = $clog2(MATRIS_BOYUT + 1);
  localparam int unsigned     BEK_W   = $clog2(ZAMAN_ASIMI + 1);
  localparam logic [SAY_W:0]  SINIR   = (SAY_W + 1)'(MATRIS_BOYUT);
  // The timeout pulse is scheduled one edge early so that hata_o is high
  // during the last (ZAMAN_ASIMI-th) CONV cycle.
  localparam logic [BEK_W-1:0] SON_BEK = BEK_W'(ZAMAN_ASIMI - 2);

  typedef enum logic [2:0] {
    SIFIRLA,
    BOSTA,
    YUKLE,
    SIL,
    CONV,
    SONUC
  } durum_t;

  durum_t             durum_q;
  logic               temizlendi_q;
  logic [SAY_W-1:0]   filtre_say_q;
  logic [SAY_W-1:0]   veri_say_q;
  logic [BEK_W-1:0]   bekle_q;
  logic [31:0]        rs1_q;
  logic [31:0]        rs2_q;
  logic [4:0]         rd_q;

  logic               komut_hazir_q;
  logic               stall_q;
  logic               blok_aktif_q;
  logic               filtre_rs1_en_q;
  logic               filtre_rs2_en_q;
  logic               filtre_sil_q;
  logic               veri_rs1_en_q;
  logic               veri_rs2_en_q;
  logic               veri_sil_q;
  logic               conv_yap_en_q;
  logic               yaz_gecerli_q;
  logic [4:0]         yaz_adres_q;
  logic [31:0]        yaz_veri_q;
  logic               hata_q;

  logic               kabul;
  logic [2:0]         f3;
  logic               cift;
  logic [SAY_W:0]     adet;
  logic [SAY_W-1:0]   hedef_say;
  logic [SAY_W:0]     yeni_say_d;
  logic               tasma;
  logic               bos_matris;
  logic               unused_buyruk_bitleri;

  assign unused_buyruk_bitleri = ^{buyruk_i[31:26], buyruk_i[24:15]};

  // Decode of the presented instruction and the fill-level check for loads.
  always_comb begin
    f3         = buyruk_i[14:12];
    cift       = buyruk_i[25];
    kabul      = (durum_q == BOSTA) && komut_gecerli_i &&
                 (buyruk_i[6:0] == OPKOD) && (f3 <= 3'd4);
    adet       = cift ? (SAY_W + 1)'(2) : (SAY_W + 1)'(1);
    // funct3[0] selects data over filter for both loads and clears.
    hedef_say  = f3[0] ? veri_say_q : filtre_say_q;
    yeni_say_d = {1'b0, hedef_say} + adet;
    tasma      = yeni_say_d > SINIR;
    bos_matris = (filtre_say_q == '0) || (veri_say_q == '0);
  end

  // Control FSM; every output is registered and set on the edge that enters
  // the state it belongs to.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      durum_q         <= SIFIRLA;
      temizlendi_q    <= 1'b0;
      filtre_say_q    <= '0;
      veri_say_q      <= '0;
      bekle_q         <= '0;
      rs1_q           <= '0;
      rs2_q           <= '0;
      rd_q            <= '0;
      komut_hazir_q   <= 1'b0;
      stall_q         <= 1'b0;
      blok_aktif_q    <= 1'b0;
      filtre_rs1_en_q <= 1'b0;
      filtre_rs2_en_q <= 1'b0;
      filtre_sil_q    <= 1'b0;
      veri_rs1_en_q   <= 1'b0;
      veri_rs2_en_q   <= 1'b0;
      veri_sil_q      <= 1'b0;
      conv_yap_en_q   <= 1'b0;
      yaz_gecerli_q   <= 1'b0;
      yaz_adres_q     <= '0;
      yaz_veri_q      <= '0;
      hata_q          <= 1'b0;
    end else begin
      filtre_rs1_en_q <= 1'b0;
      filtre_rs2_en_q <= 1'b0;
      filtre_sil_q    <= 1'b0;
      veri_rs1_en_q   <= 1'b0;
      veri_rs2_en_q   <= 1'b0;
      veri_sil_q      <= 1'b0;
      conv_yap_en_q   <= 1'b0;
      yaz_gecerli_q   <= 1'b0;
      yaz_adres_q     <= '0;
      yaz_veri_q      <= '0;
      hata_q          <= 1'b0;

      case (durum_q)
        SIFIRLA: begin
          // Outputs are all zero while reset is held, so the clear cycle is
          // produced on the first edge after release, then BOSTA follows.
          if (!temizlendi_q) begin
            temizlendi_q  <= 1'b1;
            filtre_sil_q  <= 1'b1;
            veri_sil_q    <= 1'b1;
            filtre_say_q  <= '0;
            veri_say_q    <= '0;
            blok_aktif_q  <= 1'b1;
            stall_q       <= 1'b1;
            komut_hazir_q <= 1'b0;
          end else begin
            durum_q       <= BOSTA;
            blok_aktif_q  <= 1'b0;
            stall_q       <= 1'b0;
            komut_hazir_q <= 1'b1;
          end
        end

        BOSTA: begin
          if (kabul) begin
            rs1_q         <= rs1_veri_i;
            rs2_q         <= rs2_veri_i;
            rd_q          <= buyruk_i[11:7];
            komut_hazir_q <= 1'b0;
            stall_q       <= 1'b1;
            blok_aktif_q  <= 1'b1;
            case (f3)
              3'b000, 3'b001: begin
                durum_q <= YUKLE;
                if (tasma) begin
                  hata_q <= 1'b1;
                end else if (!f3[0]) begin
                  filtre_rs1_en_q <= 1'b1;
                  filtre_rs2_en_q <= cift;
                  filtre_say_q    <= yeni_say_d[SAY_W-1:0];
                end else begin
                  veri_rs1_en_q <= 1'b1;
                  veri_rs2_en_q <= cift;
                  veri_say_q    <= yeni_say_d[SAY_W-1:0];
                end
              end
              3'b010: begin
                durum_q      <= SIL;
                filtre_sil_q <= 1'b1;
                filtre_say_q <= '0;
              end
              3'b011: begin
                durum_q    <= SIL;
                veri_sil_q <= 1'b1;
                veri_say_q <= '0;
              end
              default: begin
                durum_q       <= CONV;
                bekle_q       <= '0;
                conv_yap_en_q <= !bos_matris;
              end
            endcase
          end
        end

        YUKLE, SIL: begin
          durum_q       <= BOSTA;
          komut_hazir_q <= 1'b1;
          stall_q       <= 1'b0;
          blok_aktif_q  <= 1'b0;
        end

        CONV: begin
          // conv_yap_en_q low here means an empty matrix; hata_q high means
          // this is the timeout cycle. Both finish with a zero result.
          if (!conv_yap_en_q || hata_q) begin
            durum_q       <= SONUC;
            yaz_gecerli_q <= 1'b1;
            yaz_adres_q   <= rd_q;
          end else if (yzh_hazir_i) begin
            durum_q       <= SONUC;
            yaz_gecerli_q <= 1'b1;
            yaz_adres_q   <= rd_q;
            yaz_veri_q    <= yzh_sonuc_i;
          end else begin
            conv_yap_en_q <= 1'b1;
            bekle_q       <= bekle_q + 1'b1;
            if (bekle_q == SON_BEK) begin
              hata_q <= 1'b1;
            end
          end
        end

        SONUC: begin
          durum_q       <= BOSTA;
          komut_hazir_q <= 1'b1;
          stall_q       <= 1'b0;
          blok_aktif_q  <= 1'b0;
        end

        default: begin
          durum_q       <= BOSTA;
          komut_hazir_q <= 1'b1;
          stall_q       <= 1'b0;
          blok_aktif_q  <= 1'b0;
        end
      endcase
    end
  end

  assign komut_hazir_o   = komut_hazir_q;
  assign stall_o         = stall_q;
  assign blok_aktif_o    = blok_aktif_q;
  assign filtre_rs1_en_o = filtre_rs1_en_q;
  assign filtre_rs2_en_o = filtre_rs2_en_q;
  assign filtre_sil_o    = filtre_sil_q;
  assign veri_rs1_en_o   = veri_rs1_en_q;
  assign veri_rs2_en_o   = veri_rs2_en_q;
  assign veri_sil_o      = veri_sil_q;
  assign conv_yap_en_o   = conv_yap_en_q;
  assign yzh_rs1_o       = rs1_q;
  assign yzh_rs2_o       = rs2_q;
  assign yaz_gecerli_o   = yaz_gecerli_q;
  assign yaz_adres_o     = yaz_adres_q;
  assign yaz_veri_o      = yaz_veri_q;
  assign hata_o          = hata_q;

endmodule

// File: tb/tb_yzh_komut_birimi.sv
// Testbench for yzh_komut_birimi: directed instruction sequences with a small
// accelerator model that captures loaded elements and returns their dot product.
module tb_yzh_komut_birimi;

  logic        clk_i;
  logic        rst_ni;
  logic        komut_gecerli_i;
  logic [31:0] buyruk_i;
  logic [31:0] rs1_veri_i;
  logic [31:0] rs2_veri_i;
  logic        komut_hazir_o;
  logic        stall_o;
  logic        blok_aktif_o;
  logic        filtre_rs1_en_o;
  logic        filtre_rs2_en_o;
  logic        filtre_sil_o;
  logic        veri_rs1_en_o;
  logic        veri_rs2_en_o;
  logic        veri_sil_o;
  logic        conv_yap_en_o;
  logic [31:0] yzh_rs1_o;
  logic [31:0] yzh_rs2_o;
  logic [31:0] yzh_sonuc_i;
  logic        yzh_hazir_i;
  logic        yaz_gecerli_o;
  logic [4:0]  yaz_adres_o;
  logic [31:0] yaz_veri_o;
  logic        hata_o;

  int unsigned toplam = 0;
  int unsigned gecen  = 0;

  yzh_komut_birimi #(
    .MATRIS_BOYUT(16),
    .ZAMAN_ASIMI (64)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .komut_gecerli_i(komut_gecerli_i),
    .buyruk_i       (buyruk_i),
    .rs1_veri_i     (rs1_veri_i),
    .rs2_veri_i     (rs2_veri_i),
    .komut_hazir_o  (komut_hazir_o),
    .stall_o        (stall_o),
    .blok_aktif_o   (blok_aktif_o),
    .filtre_rs1_en_o(filtre_rs1_en_o),
    .filtre_rs2_en_o(filtre_rs2_en_o),
    .filtre_sil_o   (filtre_sil_o),
    .veri_rs1_en_o  (veri_rs1_en_o),
    .veri_rs2_en_o  (veri_rs2_en_o),
    .veri_sil_o     (veri_sil_o),
    .conv_yap_en_o  (conv_yap_en_o),
    .yzh_rs1_o      (yzh_rs1_o),
    .yzh_rs2_o      (yzh_rs2_o),
    .yzh_sonuc_i    (yzh_sonuc_i),
    .yzh_hazir_i    (yzh_hazir_i),
    .yaz_gecerli_o  (yaz_gecerli_o),
    .yaz_adres_o    (yaz_adres_o),
    .yaz_veri_o     (yaz_veri_o),
    .hata_o         (hata_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  logic herhangi_cikis;
  assign herhangi_cikis = |{komut_hazir_o, stall_o, blok_aktif_o, filtre_rs1_en_o,
                            filtre_rs2_en_o, filtre_sil_o, veri_rs1_en_o, veri_rs2_en_o,
                            veri_sil_o, conv_yap_en_o, yzh_rs1_o, yzh_rs2_o,
                            yaz_gecerli_o, yaz_adres_o, yaz_veri_o, hata_o};

  // Accelerator model: stores loaded elements, raises ready 'gecikme' cycles
  // after the first conv_yap_en_o (never when gecikme < 0).
  logic [31:0] fmem [16];
  logic [31:0] dmem [16];
  int fsay = 0;
  int dsay = 0;
  int bekle = 0;
  int gecikme = -1;

  function automatic logic [31:0] nokta();
    logic [31:0] s = '0;
    for (int i = 0; i < 16; i++)
      if (i < fsay && i < dsay) s = s + fmem[i] * dmem[i];
    return s;
  endfunction

  always @(posedge clk_i) begin
    if (filtre_sil_o) fsay = 0;
    if (veri_sil_o) dsay = 0;
    if (filtre_rs1_en_o && fsay < 16) begin fmem[fsay] = yzh_rs1_o; fsay++; end
    if (filtre_rs2_en_o && fsay < 16) begin fmem[fsay] = yzh_rs2_o; fsay++; end
    if (veri_rs1_en_o && dsay < 16) begin dmem[dsay] = yzh_rs1_o; dsay++; end
    if (veri_rs2_en_o && dsay < 16) begin dmem[dsay] = yzh_rs2_o; dsay++; end
    if (conv_yap_en_o && !yzh_hazir_i) begin
      bekle++;
      if (bekle == gecikme) begin
        yzh_hazir_i <= 1'b1;
        yzh_sonuc_i <= nokta();
      end
    end else begin
      yzh_hazir_i <= 1'b0;
      bekle = 0;
    end
  end

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                         input logic [31:0] beklenen);
    toplam++;
    if (gozlenen === beklenen) gecen++;
    else $display("FAIL %s: gozlenen=%0d beklenen=%0d", etiket, gozlenen, beklenen);
  endtask

  task automatic tik();
    @(posedge clk_i);
    #1;
  endtask

  // Waits (bounded) for komut_hazir_o, presents one instruction for a cycle.
  // On return the bench sits in the first cycle after acceptance.
  task automatic komut_ver(input logic [2:0] f3, input logic cift, input logic [4:0] rd,
                           input logic [31:0] a, input logic [31:0] b);
    int unsigned n = 0;
    while (!komut_hazir_o && n < 200) begin tik(); n++; end
    if (!komut_hazir_o) kontrol("hazir_bekle", {31'd0, komut_hazir_o}, 32'd1);
    komut_gecerli_i = 1'b1;
    buyruk_i        = {6'd0, cift, 10'd0, f3, rd, 7'b0001011};
    rs1_veri_i      = a;
    rs2_veri_i      = b;
    tik();
    komut_gecerli_i = 1'b0;
  endtask

  // Runs from the first CONV cycle until the writeback cycle (bounded).
  task automatic calistir(output int n, output int conv_d, output int hata_d,
                          output int stall_d);
    n = 0; conv_d = 0; hata_d = 0; stall_d = 0;
    while (!yaz_gecerli_o && n < 200) begin
      if (conv_yap_en_o) conv_d++;
      if (hata_o && hata_d == 0) hata_d = n + 1;
      if (!stall_o) stall_d++;
      tik();
      n++;
    end
    kontrol("sonuc_zaman", {31'd0, yaz_gecerli_o}, 32'd1);
  endtask

  int n, conv_d, hata_d, stall_d;

  initial begin
    komut_gecerli_i = 1'b0;
    buyruk_i        = '0;
    rs1_veri_i      = '0;
    rs2_veri_i      = '0;
    yzh_hazir_i     = 1'b0;
    yzh_sonuc_i     = '0;
    rst_ni          = 1'b1;
    #2 rst_ni = 1'b0;
    tik(); tik();
    kontrol("reset_cikis", {31'd0, herhangi_cikis}, 32'd0);
    rst_ni = 1'b1;
    tik();
    kontrol("sifirla_fsil", {31'd0, filtre_sil_o}, 32'd1);
    kontrol("sifirla_vsil", {31'd0, veri_sil_o}, 32'd1);
    kontrol("sifirla_blok", {31'd0, blok_aktif_o}, 32'd1);
    kontrol("sifirla_hazir", {31'd0, komut_hazir_o}, 32'd0);
    tik();
    kontrol("bosta_fsil", {31'd0, filtre_sil_o}, 32'd0);
    kontrol("bosta_hazir", {31'd0, komut_hazir_o}, 32'd1);
    kontrol("bosta_stall", {31'd0, stall_o}, 32'd0);
    kontrol("bosta_blok", {31'd0, blok_aktif_o}, 32'd0);

    // Eight paired filter loads fill the filter matrix to 16
    for (int i = 0; i < 8; i++) begin
      komut_ver(3'b000, 1'b1, 5'd0, 32'(2 * i + 1), 32'(2 * i + 2));
      kontrol("ldw_rs1_en", {31'd0, filtre_rs1_en_o}, 32'd1);
      kontrol("ldw_rs2_en", {31'd0, filtre_rs2_en_o}, 32'd1);
      kontrol("ldw_rs1", yzh_rs1_o, 32'(2 * i + 1));
      kontrol("ldw_rs2", yzh_rs2_o, 32'(2 * i + 2));
      kontrol("ldw_hata", {31'd0, hata_o}, 32'd0);
      kontrol("ldw_stall", {31'd0, stall_o}, 32'd1);
    end
    komut_ver(3'b000, 1'b1, 5'd0, 32'd17, 32'd18);
    kontrol("tasma_rs1_en", {31'd0, filtre_rs1_en_o}, 32'd0);
    kontrol("tasma_rs2_en", {31'd0, filtre_rs2_en_o}, 32'd0);
    kontrol("tasma_hata", {31'd0, hata_o}, 32'd1);
    tik();
    kontrol("tasma_hata_bitti", {31'd0, hata_o}, 32'd0);
    kontrol("tasma_hazir", {31'd0, komut_hazir_o}, 32'd1);

    // Run with data count 0: no run request, zero writeback two cycles after accept
    komut_ver(3'b100, 1'b0, 5'd7, 32'd0, 32'd0);
    calistir(n, conv_d, hata_d, stall_d);
    kontrol("bos_conv_dongu", 32'(n), 32'd1);
    kontrol("bos_conv_en", 32'(conv_d), 32'd0);
    kontrol("bos_adres", {27'd0, yaz_adres_o}, 32'd7);
    kontrol("bos_veri", yaz_veri_o, 32'd0);
    tik();
    kontrol("bos_yaz_bitti", {31'd0, yaz_gecerli_o}, 32'd0);
    kontrol("bos_hazir", {31'd0, komut_hazir_o}, 32'd1);

    // Filter of 2s, data of 3s, ready 17 cycles after the run request
    komut_ver(3'b010, 1'b0, 5'd0, 32'd0, 32'd0);
    kontrol("clrw_fsil", {31'd0, filtre_sil_o}, 32'd1);
    kontrol("clrw_vsil", {31'd0, veri_sil_o}, 32'd0);
    for (int i = 0; i < 8; i++) komut_ver(3'b000, 1'b1, 5'd0, 32'd2, 32'd2);
    for (int i = 0; i < 8; i++) begin
      komut_ver(3'b001, 1'b1, 5'd0, 32'd3, 32'd3);
      kontrol("ldx_en", {30'd0, veri_rs1_en_o, veri_rs2_en_o}, 32'd3);
    end
    gecikme = 17;
    for (int r = 5; r < 7; r++) begin
      komut_ver(3'b100, 1'b0, 5'(r), 32'd0, 32'd0);
      calistir(n, conv_d, hata_d, stall_d);
      kontrol("conv_dongu", 32'(n), 32'd18);
      kontrol("conv_en_dongu", 32'(conv_d), 32'd18);
      kontrol("conv_stall", 32'(stall_d), 32'd0);
      kontrol("conv_hata", 32'(hata_d), 32'd0);
      kontrol("conv_adres", {27'd0, yaz_adres_o}, 32'(r));
      kontrol("conv_veri", yaz_veri_o, 32'd96);
      tik();
      kontrol("conv_yaz_bitti", {31'd0, yaz_gecerli_o}, 32'd0);
    end

    // Accelerator never ready: timeout in the 64th CONV cycle
    gecikme = -1;
    komut_ver(3'b100, 1'b0, 5'd9, 32'd0, 32'd0);
    calistir(n, conv_d, hata_d, stall_d);
    kontrol("zaman_dongu", 32'(n), 32'd64);
    kontrol("zaman_hata_dongu", 32'(hata_d), 32'd64);
    kontrol("zaman_conv_en", 32'(conv_d), 32'd64);
    kontrol("zaman_adres", {27'd0, yaz_adres_o}, 32'd9);
    kontrol("zaman_veri", yaz_veri_o, 32'd0);
    kontrol("zaman_hata_sonuc", {31'd0, hata_o}, 32'd0);
    tik();
    kontrol("zaman_hazir", {31'd0, komut_hazir_o}, 32'd1);

    // Wrong opcode and unused funct3 are ignored
    komut_gecerli_i = 1'b1;
    buyruk_i = {17'd0, 3'b000, 5'd1, 7'b0110011};
    tik();
    kontrol("yoksay_opkod", {29'd0, komut_hazir_o, stall_o, filtre_rs1_en_o}, 32'd4);
    buyruk_i = {17'd0, 3'b101, 5'd1, 7'b0001011};
    tik();
    komut_gecerli_i = 1'b0;
    kontrol("yoksay_f3", {29'd0, komut_hazir_o, stall_o, conv_yap_en_o}, 32'd4);

    // Data clear, single load, fill to 15, then pair overflows and single fits
    komut_ver(3'b011, 1'b0, 5'd0, 32'd0, 32'd0);
    kontrol("clrx_sil", {30'd0, filtre_sil_o, veri_sil_o}, 32'd1);
    komut_ver(3'b001, 1'b0, 5'd0, 32'hAA, 32'h55);
    kontrol("tekli_en", {30'd0, veri_rs1_en_o, veri_rs2_en_o}, 32'd2);
    kontrol("tekli_rs1", yzh_rs1_o, 32'hAA);
    for (int i = 0; i < 7; i++) komut_ver(3'b001, 1'b1, 5'd0, 32'd3, 32'd3);
    komut_ver(3'b001, 1'b1, 5'd0, 32'd4, 32'd4);
    kontrol("sinir_cift", {29'd0, veri_rs1_en_o, veri_rs2_en_o, hata_o}, 32'd1);
    komut_ver(3'b001, 1'b0, 5'd0, 32'd4, 32'd4);
    kontrol("sinir_tek", {29'd0, veri_rs1_en_o, veri_rs2_en_o, hata_o}, 32'd4);

    // Reset in the middle of a run
    komut_ver(3'b100, 1'b0, 5'd3, 32'd0, 32'd0);
    for (int i = 0; i < 5; i++) tik();
    kontrol("rst_oncesi_conv", {31'd0, conv_yap_en_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    kontrol("rst_ani_cikis", {31'd0, herhangi_cikis}, 32'd0);
    tik();
    kontrol("rst_yaz_yok", {31'd0, herhangi_cikis}, 32'd0);
    rst_ni = 1'b1;
    tik();
    kontrol("rst_sifirla", {29'd0, filtre_sil_o, veri_sil_o, yaz_gecerli_o}, 32'd6);
    tik();
    kontrol("rst_bosta", {30'd0, komut_hazir_o, filtre_sil_o}, 32'd2);

    $display("%0d/%0d checks passed", gecen, toplam);
    $finish;
  end

endmodule

// File: doc/yzh_komut_birimi.md
Name: yzh_komut_birimi

Overview:
- Issue-side controller for the convolution accelerator; it is the initiator of the accelerator's load/clear/run protocol.
- Sits in the execute stage. Accepts decoded custom instructions with their rs1/rs2 operands, then drives the accelerator's enable, clear and run strobes.
- Tracks filter and data fill levels, stalls the pipeline while a convolution runs, and returns the result to the register-file writeback path.

Parameters:
- MATRIS_BOYUT, 16, maximum elements per matrix (filter and data each)
- ZAMAN_ASIMI, 64, cycles to wait for accelerator ready before aborting a run

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- komut_gecerli_i  input  1  instruction valid
- buyruk_i  input  32  instruction word
- rs1_veri_i  input  32  rs1 operand
- rs2_veri_i  input  32  rs2 operand
- komut_hazir_o  output  1  ready to accept an instruction
- stall_o  output  1  pipeline stall
- blok_aktif_o  output  1  accelerator output enable
- filtre_rs1_en_o, filtre_rs2_en_o, filtre_sil_o  output  1 each  filter strobes
- veri_rs1_en_o, veri_rs2_en_o, veri_sil_o  output  1 each  data strobes
- conv_yap_en_o  output  1  run request
- yzh_rs1_o, yzh_rs2_o  output  32 each  operands to accelerator
- yzh_sonuc_i  input  32  accelerator result
- yzh_hazir_i  input  1  accelerator result ready
- yaz_gecerli_o  output  1  writeback valid (one-cycle pulse)
- yaz_adres_o  output  5  destination rd
- yaz_veri_o  output  32  writeback data
- hata_o  output  1  one-cycle error pulse

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - All outputs 0; filter/data counters 0; state SIFIRLA.
- Instruction decode:
  - Opcode 7'b0001011. funct3: 000 ld_w (filter), 001 ld_x (data), 010 clr_w, 011 clr_x, 100 run.
  - funct7[0]=1 on a load means rs2 is loaded as well (two elements).
  - Any other opcode or funct3 is ignored: no state change, no error.
- States:
  - SIFIRLA: first cycle after reset release. filtre_sil_o=veri_sil_o=1, blok_aktif_o=1 → BOSTA.
  - BOSTA: komut_hazir_o=1, stall_o=0. Accept on komut_gecerli_i with a valid opcode; latch rs1, rs2, rd and funct. Next state is YUKLE, SIL or CONV.
  - YUKLE: one cycle.
    - Drive the rs1_en strobe of the addressed matrix (plus the rs2_en strobe if funct7[0]=1).
    - yzh_rs1_o/yzh_rs2_o carry the latched operands.
    - Counter += 1 or 2 → BOSTA.
    - If counter + n > MATRIS_BOYUT: no strobe, counter unchanged, hata_o=1.
  - SIL: one cycle. Assert the addressed sil strobe; that counter ← 0 → BOSTA.
  - CONV:
    - If either counter == 0: no conv_yap_en_o; result 0 → SONUC next cycle.
    - Otherwise hold conv_yap_en_o=1 until yzh_hazir_i=1, then latch yzh_sonuc_i → SONUC.
    - A wait counter runs in this state. At ZAMAN_ASIMI cycles without ready: hata_o=1, result 0 → SONUC.
  - SONUC: yaz_gecerli_o=1, yaz_adres_o=rd, yaz_veri_o=result → BOSTA.
    - rd=0 still pulses yaz_gecerli_o; the register file discards it.
- Combinational outputs:
  - stall_o=1 and komut_hazir_o=0 in every state except BOSTA.
  - blok_aktif_o=1 in SIFIRLA, YUKLE, SIL, CONV, SONUC.
- Latency:
  - Load and clear occupy 2 cycles, accept through return to BOSTA.
  - Run occupies 3+k cycles, where k is the number of cycles from the first conv_yap_en_o until yzh_hazir_i.
- Counters are 5 bits and saturate at MATRIS_BOYUT; they never wrap.
- A repeated run with no intervening load re-issues conv_yap_en_o. The accelerator returns the same result.
- Reset mid-operation aborts the instruction with no writeback, then SIFIRLA clears the accelerator.

Test Plan:
- Release reset → filtre_sil_o=veri_sil_o=1 for exactly 1 cycle, then komut_hazir_o=1, counters 0.
- Eight ld_w (funct7[0]=1) with pairs (1,2)…(15,16) → 8 cycles with filtre_rs1_en_o and filtre_rs2_en_o both high, correct operands, filter count 16. A further ld_w → no strobe, hata_o pulse.
- Load 16 filter values of 2 and 16 data values of 3; run rd=5; model asserts yzh_hazir_i 17 cycles after conv_yap_en_o with sonuc 96 → yaz_gecerli_o 1 cycle, yaz_adres_o=5, yaz_veri_o=96, stall_o high throughout.
- Run with data count 0 → conv_yap_en_o never asserted; writeback of 0 two cycles after accept.
- Run where the model never asserts ready → hata_o at cycle 64 of CONV; writeback 0; return to BOSTA.
- rst_ni low during CONV → all outputs 0 immediately, no writeback; SIFIRLA after release.
